// File: rtl/dma_io_peripheral.sv
// Device side of an 8237-style DREQ/DACK DMA handshake, backed by a local FIFO.
// Define DMA_PERIPH_SINGLE_EN for single-transfer mode; the default build is demand mode.
module dma_io_peripheral #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 8,
  parameter int REQ_THRESH = 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   enable,
  input  logic                   dir,
  output logic                   DREQ,
  input  logic                   DACK,
  input  logic                   IOR_N,
  input  logic                   IOW_N,
  input  logic                   EOP_N,
  input  logic [DATA_W-1:0]      DB_IN,
  output logic [DATA_W-1:0]      DB_OUT,
  output logic                   DB_OE,
  input  logic                   src_valid,
  input  logic [DATA_W-1:0]      src_data,
  output logic                   src_ready,
  output logic                   snk_valid,
  output logic [DATA_W-1:0]      snk_data,
  input  logic                   snk_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   done,
  output logic                   ovf_err,
  output logic                   unf_err
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0]   cnt_t;
  typedef logic [AW-1:0] ptr_t;
  localparam cnt_t DEPTH_C  = cnt_t'(DEPTH);
  localparam cnt_t THRESH_C = cnt_t'(REQ_THRESH);
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam ptr_t PTR_ONE  = ptr_t'(1);
`ifdef DMA_PERIPH_SINGLE_EN
  localparam bit SINGLE = 1'b1;
`else
  localparam bit SINGLE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  ptr_t              wr_ptr;
  ptr_t              rd_ptr;
  cnt_t              cnt_q;
  cnt_t              cnt_nxt;
  logic              dir_q;
  logic              armed_q;
  logic              ior_n_p0;
  logic              iow_n_p0;
  logic [DATA_W-1:0] db_in_p0;

  logic              full;
  logic              empty;
  logic [DATA_W-1:0] head;
  logic              rd_edge;
  logic              wr_edge;
  logic              strobe_edge;
  logic              strobe_low;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] push_data;
  logic              svc_nxt;
  logic              arm_ok;

  assign full  = (cnt_q == DEPTH_C);
  assign empty = (cnt_q == '0);
  assign head  = mem[rd_ptr];
  assign count = cnt_q;

  assign src_ready = !dir_q && !full;
  assign snk_valid = dir_q && !empty;
  assign snk_data  = head;

  assign DB_OE  = !dir_q && DACK && !IOR_N;
  assign DB_OUT = (DB_OE && !empty) ? head : '0;

  // Strobe completion is the rising edge of the strobe against its registered sample.
  assign rd_edge     = !dir_q && DACK && !ior_n_p0 && IOR_N;
  assign wr_edge     = dir_q && DACK && !iow_n_p0 && IOW_N;
  assign strobe_edge = rd_edge || wr_edge;
  assign strobe_low  = DACK && (!IOR_N || !IOW_N);

  assign push      = dir_q ? (wr_edge && !full) : (src_valid && !full);
  assign pop       = dir_q ? (snk_ready && !empty) : (rd_edge && !empty);
  assign push_data = dir_q ? db_in_p0 : src_data;

  always_comb begin
    cnt_nxt = cnt_q;
    if (push && !pop)      cnt_nxt = cnt_q + CNT_ONE;
    else if (!push && pop) cnt_nxt = cnt_q - CNT_ONE;
  end

  assign svc_nxt = dir_q ? (cnt_nxt != DEPTH_C) : (cnt_nxt != '0);
  assign arm_ok  = dir_q ? ((DEPTH_C - cnt_q) >= THRESH_C) : (cnt_q >= THRESH_C);

  // Stage p0: strobe samples and bus-write data capture
  always_ff @(posedge CLK) begin
    if (!IOW_N && DACK) db_in_p0 <= DB_IN;
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt_q    <= '0;
      ovf_err  <= 1'b0;
      unf_err  <= 1'b0;
      ior_n_p0 <= 1'b1;
      iow_n_p0 <= 1'b1;
    end else begin
      ior_n_p0 <= IOR_N;
      iow_n_p0 <= IOW_N;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      cnt_q <= cnt_nxt;
      if (wr_edge && full)  ovf_err <= 1'b1;
      if (rd_edge && empty) unf_err <= 1'b1;
    end
  end

  // Request FSM; DREQ and done are registered alongside the state
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      DREQ    <= 1'b0;
      done    <= 1'b0;
      dir_q   <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      done <= 1'b0;
      if (!enable) armed_q <= 1'b1;
      case (state)
        IDLE: begin
          DREQ  <= 1'b0;
          dir_q <= dir;
          if (enable && armed_q && (dir == dir_q) && arm_ok) begin
            state <= REQ;
            DREQ  <= 1'b1;
          end
        end
        REQ: begin
          if (!EOP_N) begin
            state   <= DONE;
            DREQ    <= 1'b0;
            done    <= 1'b1;
            armed_q <= 1'b0;
          end else if (SINGLE && strobe_edge) begin
            DREQ  <= 1'b0;
            state <= svc_nxt ? REQ : IDLE;
          end else if (!enable) begin
            state <= IDLE;
            DREQ  <= 1'b0;
          end else begin
            DREQ <= 1'b1;
            if (DACK && DREQ) state <= XFER;
          end
        end
        XFER: begin
          if (!EOP_N) begin
            state   <= DONE;
            DREQ    <= 1'b0;
            done    <= 1'b1;
            armed_q <= 1'b0;
          end else if (!enable && !strobe_low) begin
            state <= IDLE;
            DREQ  <= 1'b0;
          end else if (SINGLE && strobe_edge) begin
            DREQ  <= 1'b0;
            state <= svc_nxt ? REQ : IDLE;
          end else if (!DACK) begin
            DREQ  <= svc_nxt;
            state <= svc_nxt ? REQ : IDLE;
          end else begin
            DREQ <= svc_nxt;
          end
        end
        DONE: begin
          DREQ  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          DREQ  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_io_peripheral.sv
// Randomized self-checking bench for dma_io_peripheral against a queue-based FIFO model.
// Honours DMA_PERIPH_SINGLE_EN when predicting DREQ after each strobe.
module tb_dma_io_peripheral;

  localparam int DW = 8;
  localparam int DP = 8;
`ifdef DMA_PERIPH_SINGLE_EN
  localparam bit SINGLE = 1'b1;
`else
  localparam bit SINGLE = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESET, enable, dir, DACK, IOR_N, IOW_N, EOP_N;
  logic [DW-1:0] DB_IN, src_data;
  logic          src_valid, snk_ready;
  logic          DREQ, DB_OE, src_ready, snk_valid, done, ovf_err, unf_err;
  logic [DW-1:0] DB_OUT, snk_data;
  logic [$clog2(DP):0] count;

  dma_io_peripheral #(.DATA_W(DW), .DEPTH(DP), .REQ_THRESH(1)) dut (
    .CLK(CLK), .RESET(RESET), .enable(enable), .dir(dir), .DREQ(DREQ),
    .DACK(DACK), .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N(EOP_N),
    .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .snk_valid(snk_valid), .snk_data(snk_data), .snk_ready(snk_ready),
    .count(count), .done(done), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] q[$];
  bit exp_ovf = 1'b0;
  bit exp_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] model_head();
    return (q.size() > 0) ? {24'h0, q[0]} : 32'h0;
  endfunction

  task automatic status(input string tag);
    chk({tag, "_count"}, 32'(count), q.size());
    chk({tag, "_ovf"}, 32'(ovf_err), 32'(exp_ovf));
    chk({tag, "_unf"}, 32'(unf_err), 32'(exp_unf));
  endtask

  task automatic src_push(input logic [DW-1:0] d);
    src_valid = 1'b1;
    src_data  = d;
    #1 chk("src_ready", 32'(src_ready), 32'd1);
    cyc();
    src_valid = 1'b0;
    q.push_back(d);
    chk("push_count", 32'(count), q.size());
  endtask

  task automatic ior_pulse(input bit active, input bit eop);
    IOR_N = 1'b0;
    #1;
    chk("db_oe_low", 32'(DB_OE), 32'd1);
    chk("db_out", 32'(DB_OUT), model_head());
    cyc();
    chk("dreq_mid_rd", 32'(DREQ), 32'(active && q.size() > 0));
    chk("db_out_hold", 32'(DB_OUT), model_head());
    IOR_N = 1'b1;
    EOP_N = eop ? 1'b0 : 1'b1;
    #1 chk("db_oe_high", 32'(DB_OE), 32'd0);
    cyc();
    EOP_N = 1'b1;
    if (q.size() > 0) void'(q.pop_front());
    else exp_unf = 1'b1;
    chk("dreq_after_rd", 32'(DREQ), 32'(active && !eop && !SINGLE && q.size() > 0));
    if (eop) chk("done_pulse", 32'(done), 32'd1);
    status("rd");
  endtask

  task automatic iow_pulse(input logic [DW-1:0] d, input bit active);
    IOW_N = 1'b0;
    DB_IN = d;
    cyc();
    chk("dreq_mid_wr", 32'(DREQ), 32'(active && q.size() < DP));
    IOW_N = 1'b1;
    DB_IN = ~d;
    cyc();
    if (q.size() < DP) q.push_back(d);
    else exp_ovf = 1'b1;
    chk("dreq_after_wr", 32'(DREQ), 32'(active && !SINGLE && q.size() < DP));
    status("wr");
  endtask

  initial begin
    logic [DW-1:0] d;
    int n;
    RESET = 1'b1; enable = 1'b0; dir = 1'b0; DACK = 1'b0;
    IOR_N = 1'b1; IOW_N = 1'b1; EOP_N = 1'b1;
    DB_IN = '0; src_data = '0; src_valid = 1'b0; snk_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_dreq", 32'(DREQ), 32'd0);
    chk("rst_db_oe", 32'(DB_OE), 32'd0);
    chk("rst_db_out", 32'(DB_OUT), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_snk_valid", 32'(snk_valid), 32'd0);
    status("rst");
    RESET = 1'b0;
    cyc();

    // device-to-memory, two entries
    src_push(8'hA5);
    src_push(8'h3C);
    enable = 1'b1;
    cyc();
    chk("s1_dreq_req", 32'(DREQ), 32'd1);
    DACK = 1'b1;
    cyc();
    ior_pulse(1'b1, 1'b0);
    ior_pulse(1'b1, 1'b0);
    DACK = 1'b0; enable = 1'b0;
    cyc();
    chk("s1_dreq_idle", 32'(DREQ), 32'd0);

    // memory-to-device fill, overflow, then local drain
    dir = 1'b1;
    cyc();
    chk("s2_src_ready", 32'(src_ready), 32'd0);
    chk("s2_snk_valid", 32'(snk_valid), 32'd0);
    enable = 1'b1;
    cyc();
    chk("s2_dreq_req", 32'(DREQ), 32'd1);
    DACK = 1'b1;
    cyc();
    for (int i = 0; i < DP; i++) iow_pulse(8'(i + 1), 1'b1);
    iow_pulse(8'($urandom_range(0, 255)), 1'b1);
    DACK = 1'b0; enable = 1'b0;
    cyc();
    for (int i = 0; i < DP; i++) begin
      chk("s2_snk_valid_d", 32'(snk_valid), 32'd1);
      chk("s2_snk_data", 32'(snk_data), model_head());
      snk_ready = 1'b1;
      cyc();
      snk_ready = 1'b0;
      void'(q.pop_front());
      chk("s2_drain_count", 32'(count), q.size());
    end
    chk("s2_snk_empty", 32'(snk_valid), 32'd0);

    // EOP during the second read edge, then re-arm by enable toggle
    dir = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) src_push(8'($urandom_range(0, 255)));
    enable = 1'b1;
    cyc();
    chk("s3_dreq_req", 32'(DREQ), 32'd1);
    DACK = 1'b1;
    cyc();
    ior_pulse(1'b1, 1'b0);
    ior_pulse(1'b1, 1'b1);
    cyc();
    chk("s3_done_clear", 32'(done), 32'd0);
    chk("s3_dreq_after_done", 32'(DREQ), 32'd0);
    DACK = 1'b0;
    repeat (3) cyc();
    chk("s3_no_rearm", 32'(DREQ), 32'd0);
    enable = 1'b0;
    cyc();
    enable = 1'b1;
    cyc();
    chk("s3_rearm", 32'(DREQ), 32'd1);
    DACK = 1'b1;
    cyc();
    ior_pulse(1'b1, 1'b0);
    DACK = 1'b0; enable = 1'b0;
    cyc();

    // underflow on empty read strobe
    DACK = 1'b1;
    ior_pulse(1'b0, 1'b0);
    DACK = 1'b0;
    repeat (2) cyc();
    chk("s4_unf_sticky", 32'(unf_err), 32'd1);

    // same-cycle local push and bus pop at count 4
    for (int i = 0; i < 4; i++) src_push(8'($urandom_range(0, 255)));
    DACK = 1'b1;
    IOR_N = 1'b0;
    cyc();
    d = 8'($urandom_range(0, 255));
    src_valid = 1'b1; src_data = d; IOR_N = 1'b1;
    cyc();
    src_valid = 1'b0;
    void'(q.pop_front());
    q.push_back(d);
    chk("s5_count_same", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) ior_pulse(1'b0, 1'b0);
    DACK = 1'b0;
    cyc();

    // randomized demand transfers
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, DP - 1);
      for (int i = 0; i < n; i++) src_push(8'($urandom_range(0, 255)));
      enable = 1'b1;
      cyc();
      chk("rnd_dreq_req", 32'(DREQ), 32'd1);
      DACK = 1'b1;
      cyc();
      for (int i = 0; i < n; i++) ior_pulse(1'b1, 1'b0);
      DACK = 1'b0; enable = 1'b0;
      cyc();
      chk("rnd_dreq_idle", 32'(DREQ), 32'd0);
    end

    // reset in the middle of a read transfer
    for (int i = 0; i < 3; i++) src_push(8'($urandom_range(0, 255)));
    enable = 1'b1;
    cyc();
    DACK = 1'b1;
    cyc();
    IOR_N = 1'b0;
    #1 chk("s6_db_oe_pre", 32'(DB_OE), 32'd1);
    cyc();
    RESET = 1'b1; IOR_N = 1'b1; DACK = 1'b0;
    cyc();
    q.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    chk("s6_dreq", 32'(DREQ), 32'd0);
    chk("s6_db_oe", 32'(DB_OE), 32'd0);
    chk("s6_done", 32'(done), 32'd0);
    status("s6");
    RESET = 1'b0; enable = 1'b0;
    cyc();
    chk("s6_idle_dreq", 32'(DREQ), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_io_peripheral.md
Name: dma_io_peripheral

Overview:
- DMA-capable I/O device model: the device side of the 8237-style DREQ/DACK/IOR_N/IOW_N/EOP_N handshake.
- Buffers local data in a FIFO and raises DREQ to request service.
- Sources bus data on I/O-read cycles (device-to-memory) and sinks bus data on I/O-write cycles (memory-to-device).
- Serves as the bus-side peer for controller-level verification and as a reusable peripheral.

Parameters:
DATA_W, 8, data bus and FIFO width
DEPTH, 8, FIFO entries (power of two, >=2)
REQ_THRESH, 1, fill level (dir 0) or free space (dir 1) required to raise DREQ; 1..DEPTH

Ports:
CLK  in  1  clock; all logic on posedge
RESET  in  1  synchronous reset, active-high
enable  in  1  arms DMA servicing
dir  in  1  0 = device-to-memory (I/O read), 1 = memory-to-device (I/O write); sampled only in IDLE
DREQ  out  1  DMA request to controller
DACK  in  1  DMA acknowledge, active-high
IOR_N  in  1  I/O read strobe, active-low
IOW_N  in  1  I/O write strobe, active-low
EOP_N  in  1  end of process / terminal count, active-low
DB_IN  in  DATA_W  bus data for I/O writes
DB_OUT  out  DATA_W  bus data for I/O reads
DB_OE  out  1  bus drive enable
src_valid/src_data/src_ready  in/in/out  1/DATA_W/1  local producer push (dir 0)
snk_valid/snk_data/snk_ready  out/out/in  1/DATA_W/1  local consumer pop (dir 1)
count  out  $clog2(DEPTH)+1  FIFO occupancy
done  out  1  one-cycle pulse on termination
ovf_err, unf_err  out  1  sticky protocol-error flags

Behaviour:
- Reset: DREQ=0, DB_OE=0, DB_OUT=0, done=0, ovf_err=0, unf_err=0, count=0, snk_valid=0, state=IDLE, latched dir=0. RESET mid-transfer aborts immediately; FIFO contents are discarded.
- Local side:
  - src_ready = (dir_q==0) && !full.
  - snk_valid = (dir_q==1) && !empty; snk_data = FIFO head.
  - Handshake: transfer when valid&&ready; single-cycle push/pop; no bus activity required.
- FSM states: IDLE, REQ, XFER, DONE.
  - IDLE: DREQ=0; latch dir. Go to REQ when enable && (dir_q==0 ? count>=REQ_THRESH : DEPTH-count>=REQ_THRESH).
  - REQ: DREQ=1. Go to XFER when DACK is sampled 1.
  - XFER: DREQ=1 while the service condition holds (dir 0: count>0; dir 1: !full). Otherwise DREQ drops the cycle after the strobe that made it false. If DACK drops while DREQ=0, return to IDLE; if DACK drops while the condition still holds, return to REQ.
  - DONE: done=1 for one cycle, DREQ=0; then IDLE. Re-arm requires enable low then high.
- Bus read (dir 0, DACK=1, IOR_N=0): DB_OE=1 combinationally; DB_OUT=FIFO head. Pop on the IOR_N rising edge (IOR_N_q==0 && IOR_N==1 && DACK). DB_OE=0 whenever IOR_N=1 or DACK=0.
- Bus write (dir 1, DACK=1, IOW_N=0): DB_IN is registered every cycle while low; the last registered value is pushed on the IOW_N rising edge.
- Simultaneous local pop/push and bus push/pop in the same cycle: count unchanged; data ordering is preserved.
- Errors:
  - IOR_N strobe with FIFO empty: DB_OUT=0, no pop, unf_err set.
  - IOW_N rising edge with FIFO full: data dropped, ovf_err set.
  - Strobe with DACK=0: ignored.
  - Error flags are cleared only by RESET.
- EOP_N sampled 0 while in REQ or XFER: complete any strobe edge occurring that same cycle, then go to DONE. EOP_N in IDLE is ignored.
- enable deasserted in REQ returns to IDLE. enable deasserted in XFER finishes the current strobe, then goes to IDLE.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.

Optional Feature:
- Macro DMA_PERIPH_SINGLE_EN.
- Defined: single-transfer mode. DREQ deasserts for at least one cycle after every completed strobe edge and reasserts only if the service condition holds, with re-entry through REQ.
- Undefined: demand mode as above; DREQ stays high across consecutive strobes.

Test Plan:
- dir=0, REQ_THRESH=1, push 0xA5,0x3C, enable=1 -> DREQ=1 next cycle; DACK=1 then two IOR_N pulses -> DB_OUT 0xA5 then 0x3C with DB_OE only while IOR_N low; count 2->0; DREQ drops after the second strobe.
- dir=1, DEPTH=8, empty FIFO, enable -> DREQ=1; 8 IOW_N pulses with DB_IN 0x01..0x08 -> count=8, DREQ=0; consumer pops 0x01..0x08 in order.
- dir=0, 3 entries, EOP_N=0 during the second IOR_N rising edge -> 2 pops, count=1, done pulse, DREQ=0, no reassert until enable toggles.
- IOR_N pulse with DACK=1 and empty FIFO -> DB_OUT=0, unf_err=1 sticky; full FIFO plus IOW_N -> ovf_err=1, count stays DEPTH.
- Same-cycle src push and IOR_N-edge pop at count=4 -> count stays 4, bus data order intact.
- RESET asserted mid-XFER -> next cycle DREQ=0, DB_OE=0, count=0, state IDLE; with DMA_PERIPH_SINGLE_EN, DREQ shows a low cycle between each strobe.
